pool2_stream: RTL

POOL2_STREAM -- requirements
Module: pool2_stream

---
 rtl/pool2_stream_pkg.sv | 18 +
 rtl/pool2_lane.sv | 53 +++++
 rtl/pool2_stream.sv | 82 ++++++++
 3 files changed

// File: rtl/pool2_stream_pkg.sv
// Shared constants for the conv2 -> pool2 pipeline.
//   POOL_IN_W / POOL_IN_H : default conv2 feature-map size (both even)
//   POOL_DW               : default unsigned pixel width
//   NUM_LANES             : channels carried in parallel through pool2
//   cnt_w()               : counter width for a 0..n-1 counter, never below 2
//                           so that col[CW-1:1] is always a legal slice
package pool2_stream_pkg;

    localparam int POOL_IN_W = 8;
    localparam int POOL_IN_H = 8;
    localparam int POOL_DW   = 8;
    localparam int NUM_LANES = 3;

    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 2;
    endfunction

endpackage

// File: rtl/pool2_lane.sv
// One channel of the 2x2 max pool.
//   clk, rst_n : clock, async active-low reset
//   in_valid   : pixel beat qualifier (shared across lanes)
//   col        : shared column counter value for this beat
//   row_odd    : parity of the shared row counter for this beat
//   pix        : this channel's input pixel
//   out_pix    : pooled result, updated one clock after the closing beat
//                of a 2x2 window and held otherwise
module pool2_lane
    import pool2_stream_pkg::*;
#(
    parameter  int IN_W = POOL_IN_W,
    parameter  int IN_H = POOL_IN_H,
    parameter  int DW   = POOL_DW,
    localparam int CW   = cnt_w(IN_W),
    localparam int BW   = CW - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [CW-1:0] col,
    input  logic          row_odd,
    input  logic [DW-1:0] pix,
    output logic [DW-1:0] out_pix
);

    logic [DW-1:0] hold;
    logic [DW-1:0] rowbuf [IN_W/2];
    logic [BW-1:0] idx;
    logic [DW-1:0] hmax;
    logic [DW-1:0] rb;

    // Pair index within the row: col>>1.
    assign idx  = col[CW-1:1];
    assign hmax = (hold > pix) ? hold : pix;
    assign rb   = rowbuf[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold    <= '0;
            out_pix <= '0;
            for (int i = 0; i < IN_W/2; i++) rowbuf[i] <= '0;
        end else if (in_valid) begin
            if (!col[0])
                hold <= pix;
            else if (!row_odd)
                rowbuf[idx] <= hmax;       // top half of the window
            else
                out_pix <= (rb > hmax) ? rb : hmax;
        end
    end

endmodule

// File: rtl/pool2_stream.sv
// 2x2/stride-2 max pool over the 3-channel raster stream from conv2.
// No backpressure: every in_valid beat is consumed.
//   clk, rst_n          : clock, async active-low reset
//   in_valid            : one raster-order pixel per high cycle, gaps allowed
//   in_1, in_2, in_3    : channel pixels (unsigned)
//   out_valid           : single-cycle qualifier for out_1..out_3
//   out_1, out_2, out_3 : pooled pixels, held while out_valid is low
//   frame_done          : pulses with the last out_valid of each frame
module pool2_stream
    import pool2_stream_pkg::*;
#(
    parameter int IN_W = POOL_IN_W,
    parameter int IN_H = POOL_IN_H,
    parameter int DW   = POOL_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_1,
    input  logic [DW-1:0] in_2,
    input  logic [DW-1:0] in_3,
    output logic          out_valid,
    output logic [DW-1:0] out_1,
    output logic [DW-1:0] out_2,
    output logic [DW-1:0] out_3,
    output logic          frame_done
);

    localparam int CW = cnt_w(IN_W);
    localparam int RW = cnt_w(IN_H);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last, row_last;

    logic [NUM_LANES-1:0][DW-1:0] in_pix;
    logic [NUM_LANES-1:0][DW-1:0] out_pix;

    assign col_last = (col == CW'(IN_W - 1));
    assign row_last = (row == RW'(IN_H - 1));

    // Shared counters; the last beat of a frame wraps both so the next
    // beat starts a new frame without an idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= in_valid & col[0] & row[0];
            frame_done <= in_valid & col_last & row_last;
            if (in_valid) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign in_pix = {in_3, in_2, in_1};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        pool2_lane #(.IN_W(IN_W), .IN_H(IN_H), .DW(DW)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .col      (col),
            .row_odd  (row[0]),
            .pix      (in_pix[g]),
            .out_pix  (out_pix[g])
        );
    end

    assign out_1 = out_pix[0];
    assign out_2 = out_pix[1];
    assign out_3 = out_pix[2];

endmodule
